// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and
// the data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with valid/ready handshake and LATENCY wait states.
// Optional feature macro DMEM_ACCESS_COUNT_EN adds saturating rd/wr/err access counters.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count,
    output logic [15:0]      err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    // Misaligned, or beyond the array: upper bits must be zero so nothing aliases.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    endfunction

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r, cnt_nxt_s;
    logic                accept_s, enter_resp_s;
    logic                write_r;
    logic [31:0]         addr_r, wdata_r;
    logic                err_s;
    logic [ADDR_W-1:0]   index_s;
    logic                ready_r, stall_r, resp_valid_r, resp_err_r;
    logic [31:0]         resp_rdata_r;
    logic [31:0]         mem [DEPTH];

    assign err_s   = addr_err(addr_r);
    assign index_s = addr_r[ADDR_W+1:2];

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = LAT_M1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request capture; later changes on the request fields are never re-sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_r <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            write_r <= bus.req_write;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end
    end

    // Handshake outputs registered from the next state; load data held until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r      <= 1'b1;
            stall_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            ready_r      <= (state_nxt_s == ST_IDLE);
            stall_r      <= (state_nxt_s != ST_IDLE);
            resp_valid_r <= enter_resp_s;
            if (enter_resp_s) begin
                resp_err_r   <= err_s;
                resp_rdata_r <= (write_r || err_s) ? 32'd0 : mem[index_s];
            end else if (state_r == ST_RESP) begin
                resp_err_r <= 1'b0;
            end
        end
    end

    // Array write on the edge entering RESP; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp_s && write_r && !err_s) begin
            mem[index_s] <= wdata_r;
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.stall      = stall_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

`ifdef DMEM_ACCESS_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] rd_count_r, wr_count_r, err_count_r;

    // Saturating access counters, bumped on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_r  <= 16'd0;
            wr_count_r  <= 16'd0;
            err_count_r <= 16'd0;
        end else if (enter_resp_s) begin
            if (err_s) begin
                err_count_r <= sat_inc(err_count_r);
            end else if (write_r) begin
                wr_count_r <= sat_inc(wr_count_r);
            end else begin
                rd_count_r <= sat_inc(rd_count_r);
            end
        end
    end

    assign rd_count  = rd_count_r;
    assign wr_count  = wr_count_r;
    assign err_count = err_count_r;
`endif

endmodule
